// File: rtl/atm_session_ctrl_if.sv
// Bundle of front-panel strobes, lookup request/result and display/status
// signals exchanged with the ATM session controller.
`timescale 1ns/1ps
interface atm_session_ctrl_if;
   // Front-panel strobes and data
   logic        card_valid;
   logic [11:0] card_acc;
   logic        pin_valid;
   logic [3:0]  pin_in;
   logic        menu_valid;
   logic [1:0]  menu_sel;
   logic        amount_valid;
   logic [15:0] amount;
   // Account lookup request and result
   logic [11:0] auth_acc;
   logic [3:0]  auth_pin;
   logic        auth_action;
   logic        auth_deauth;
   logic        auth_success;
   logic [3:0]  auth_index;
   // Status and display
   logic [3:0]  state;
   logic [15:0] balance_out;
   logic        balance_valid;
   logic [2:0]  err;

   // Environment side: front panel, lookup and display
   modport master (
      output card_valid, card_acc, pin_valid, pin_in,
      output menu_valid, menu_sel, amount_valid, amount,
      output auth_success, auth_index,
      input  auth_acc, auth_pin, auth_action, auth_deauth,
      input  state, balance_out, balance_valid, err
   );

   // Session controller side
   modport slave (
      input  card_valid, card_acc, pin_valid, pin_in,
      input  menu_valid, menu_sel, amount_valid, amount,
      input  auth_success, auth_index,
      output auth_acc, auth_pin, auth_action, auth_deauth,
      output state, balance_out, balance_valid, err
   );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: drives the account lookup, checks PINs with
// lockout, owns per-account balances and enforces an inactivity timeout.
`timescale 1ns/1ps
module atm_session_ctrl #(
   parameter int NUM_ACC        = 10,
   parameter int MAX_TRIES      = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int INIT_BALANCE   = 500
) (
   input logic             clk,
   input logic             rst_n,
   atm_session_ctrl_if.slave bus
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [3:0]       NUM_ACC_C   = 4'(NUM_ACC);
   localparam logic [TRY_W-1:0] MAX_TRIES_C = TRY_W'(MAX_TRIES);
   localparam logic [TMO_W-1:0] TMO_LAST_C  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0]      INIT_BAL_C  = 16'(INIT_BALANCE);

   typedef enum logic [3:0] {
      S_WAITING   = 4'd0,
      S_FIND_REQ  = 4'd1,
      S_FIND_CHK  = 4'd2,
      S_PIN_WAIT  = 4'd3,
      S_AUTH_REQ  = 4'd4,
      S_AUTH_CHK  = 4'd5,
      S_MENU      = 4'd6,
      S_BALANCE   = 4'd7,
      S_WITHDRAW  = 4'd8,
      S_WD_SHOW   = 4'd9,
      S_DEAUTH    = 4'd10
   } state_t;

   state_t             r_state;
   logic [11:0]        r_acc;
   logic [3:0]         r_pin;
   logic               r_action;
   logic               r_deauth;
   logic [15:0]        r_bal_out;
   logic               r_bal_valid;
   logic [2:0]         r_err;
   logic [3:0]         r_idx;
   logic [TRY_W-1:0]   r_tries;
   logic [TMO_W-1:0]   r_tmo;
   logic [15:0]        r_balance [NUM_ACC];
   logic [NUM_ACC-1:0] r_lock;

   logic               w_idle_state;
   logic               w_strobe_acc;
   logic               w_tmo_hit;
   logic [TMO_W-1:0]   w_tmo_next;
   logic               w_idx_ok;
   logic               w_find_locked;
   logic [15:0]        w_cur_bal;
   logic [TRY_W-1:0]   w_tries_inc;

   assign bus.state         = r_state;
   assign bus.auth_acc      = r_acc;
   assign bus.auth_pin      = r_pin;
   assign bus.auth_action   = r_action;
   assign bus.auth_deauth   = r_deauth;
   assign bus.balance_out   = r_bal_out;
   assign bus.balance_valid = r_bal_valid;
   assign bus.err           = r_err;

   // Decode strobe acceptance, timeout progress and lookup result qualifiers
   always_comb begin
      w_idle_state  = 1'b0;
      w_strobe_acc  = 1'b0;
      w_tmo_next    = '0;
      w_idx_ok      = (bus.auth_index < NUM_ACC_C);
      w_find_locked = 1'b0;
      w_cur_bal     = r_balance[r_idx];
      w_tries_inc   = r_tries + TRY_W'(1);

      case (r_state)
         S_WAITING:  begin w_idle_state = 1'b0; w_strobe_acc = bus.card_valid;   end
         S_PIN_WAIT: begin w_idle_state = 1'b1; w_strobe_acc = bus.pin_valid;    end
         S_MENU:     begin w_idle_state = 1'b1; w_strobe_acc = bus.menu_valid;   end
         S_WITHDRAW: begin w_idle_state = 1'b1; w_strobe_acc = bus.amount_valid; end
         default:    begin w_idle_state = 1'b0; w_strobe_acc = 1'b0;             end
      endcase

      // An accepted strobe on the last idle cycle takes priority over timeout
      w_tmo_hit = w_idle_state && !w_strobe_acc && (r_tmo == TMO_LAST_C);

      if (!w_idle_state || w_strobe_acc || w_tmo_hit) begin
         w_tmo_next = '0;
      end else begin
         w_tmo_next = r_tmo + TMO_W'(1);
      end

      if (w_idx_ok) begin
         w_find_locked = r_lock[bus.auth_index];
      end else begin
         w_find_locked = 1'b0;
      end
   end

   // Session FSM with registered outputs, balance store and lockout flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_WAITING;
         r_acc       <= 12'd0;
         r_pin       <= 4'd0;
         r_action    <= 1'b0;
         r_deauth    <= 1'b0;
         r_bal_out   <= 16'd0;
         r_bal_valid <= 1'b0;
         r_err       <= 3'd0;
         r_idx       <= 4'd0;
         r_tries     <= '0;
         r_tmo       <= '0;
         r_lock      <= '0;
         for (int i = 0; i < NUM_ACC; i++) begin
            r_balance[i] <= INIT_BAL_C;
         end
      end else begin
         r_deauth    <= 1'b0;
         r_bal_valid <= 1'b0;
         r_tmo       <= w_tmo_next;

         case (r_state)
            S_WAITING: begin
               if (bus.card_valid) begin
                  r_acc    <= bus.card_acc;
                  r_action <= 1'b0;
                  r_err    <= 3'd0;
                  r_tries  <= '0;
                  r_state  <= S_FIND_REQ;
               end
            end

            S_FIND_REQ: r_state <= S_FIND_CHK;

            S_FIND_CHK: begin
               if (!bus.auth_success || !w_idx_ok) begin
                  r_err   <= 3'd1;
                  r_state <= S_WAITING;
               end else if (w_find_locked) begin
                  r_err   <= 3'd3;
                  r_state <= S_WAITING;
               end else begin
                  r_idx   <= bus.auth_index;
                  r_state <= S_PIN_WAIT;
               end
            end

            S_PIN_WAIT: begin
               if (bus.pin_valid) begin
                  r_pin    <= bus.pin_in;
                  r_action <= 1'b1;
                  r_state  <= S_AUTH_REQ;
               end else if (w_tmo_hit) begin
                  r_err    <= 3'd5;
                  r_deauth <= 1'b1;
                  r_acc    <= 12'd0;
                  r_pin    <= 4'd0;
                  r_action <= 1'b0;
                  r_state  <= S_DEAUTH;
               end
            end

            S_AUTH_REQ: r_state <= S_AUTH_CHK;

            S_AUTH_CHK: begin
               if (bus.auth_success && (bus.auth_index == r_idx)) begin
                  r_tries <= '0;
                  r_err   <= 3'd0;
                  r_state <= S_MENU;
               end else if (w_tries_inc == MAX_TRIES_C) begin
                  r_tries       <= w_tries_inc;
                  r_lock[r_idx] <= 1'b1;
                  r_err         <= 3'd3;
                  r_deauth      <= 1'b1;
                  r_acc         <= 12'd0;
                  r_pin         <= 4'd0;
                  r_action      <= 1'b0;
                  r_state       <= S_DEAUTH;
               end else begin
                  r_tries <= w_tries_inc;
                  r_err   <= 3'd2;
                  r_state <= S_PIN_WAIT;
               end
            end

            S_MENU: begin
               if (bus.menu_valid) begin
                  r_err <= 3'd0;
                  case (bus.menu_sel)
                     2'b01: begin
                        r_bal_out   <= w_cur_bal;
                        r_bal_valid <= 1'b1;
                        r_state     <= S_BALANCE;
                     end
                     2'b10: r_state <= S_WITHDRAW;
                     2'b11: begin
                        r_deauth <= 1'b1;
                        r_acc    <= 12'd0;
                        r_pin    <= 4'd0;
                        r_action <= 1'b0;
                        r_state  <= S_DEAUTH;
                     end
                     default: r_state <= S_MENU;
                  endcase
               end else if (w_tmo_hit) begin
                  r_err    <= 3'd5;
                  r_deauth <= 1'b1;
                  r_acc    <= 12'd0;
                  r_pin    <= 4'd0;
                  r_action <= 1'b0;
                  r_state  <= S_DEAUTH;
               end
            end

            S_BALANCE: r_state <= S_MENU;

            S_WITHDRAW: begin
               if (bus.amount_valid) begin
                  if (bus.amount > w_cur_bal) begin
                     r_err   <= 3'd4;
                     r_state <= S_MENU;
                  end else begin
                     r_balance[r_idx] <= w_cur_bal - bus.amount;
                     r_bal_out        <= w_cur_bal - bus.amount;
                     r_bal_valid      <= 1'b1;
                     r_state          <= S_WD_SHOW;
                  end
               end else if (w_tmo_hit) begin
                  r_err    <= 3'd5;
                  r_deauth <= 1'b1;
                  r_acc    <= 12'd0;
                  r_pin    <= 4'd0;
                  r_action <= 1'b0;
                  r_state  <= S_DEAUTH;
               end
            end

            S_WD_SHOW: r_state <= S_MENU;

            S_DEAUTH: r_state <= S_WAITING;

            default: r_state <= S_WAITING;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for the ATM session controller with a behavioural
// account/PIN lookup table standing in for the authentication block.
`timescale 1ns/1ps
module tb_atm_session_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   atm_session_ctrl_if bus ();

   atm_session_ctrl #(
      .NUM_ACC(10), .MAX_TRIES(3), .TIMEOUT_CYCLES(1000), .INIT_BALANCE(500)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] acc_of(input int i);
      case (i)
         0: return 12'd2749;
         1: return 12'd2175;
         2: return 12'd2429;
         3: return 12'd2910;
         default: return 12'(3000 + i);
      endcase
   endfunction

   function automatic logic [3:0] pin_of(input int i);
      case (i)
         0: return 4'd0;
         1: return 4'd1;
         2: return 4'd2;
         3: return 4'd7;
         default: return 4'(i);
      endcase
   endfunction

   // Combinational account lookup: FIND matches account, AUTHENTICATE also the PIN
   always_comb begin
      bus.auth_success = 1'b0;
      bus.auth_index   = 4'hF;
      for (int i = 0; i < 10; i++) begin
         if (bus.auth_acc == acc_of(i) && (!bus.auth_action || bus.auth_pin == pin_of(i))) begin
            bus.auth_success = 1'b1;
            bus.auth_index   = 4'(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic card(input logic [11:0] a);
      bus.card_valid = 1'b1; bus.card_acc = a;
      tick();
      bus.card_valid = 1'b0;
   endtask

   task automatic pin(input logic [3:0] p);
      bus.pin_valid = 1'b1; bus.pin_in = p;
      tick();
      bus.pin_valid = 1'b0;
   endtask

   task automatic menu(input logic [1:0] s);
      bus.menu_valid = 1'b1; bus.menu_sel = s;
      tick();
      bus.menu_valid = 1'b0;
   endtask

   task automatic amt(input logic [15:0] a);
      bus.amount_valid = 1'b1; bus.amount = a;
      tick();
      bus.amount_valid = 1'b0;
   endtask

   task automatic to_menu(input string tag, input logic [11:0] a, input logic [3:0] p);
      card(a); tick(); tick();
      pin(p); tick(); tick();
      check({tag, "_menu_state"}, 32'(bus.state), 32'd6);
      check({tag, "_menu_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      bus.card_valid = 1'b0; bus.card_acc = 12'd0;
      bus.pin_valid = 1'b0;  bus.pin_in = 4'd0;
      bus.menu_valid = 1'b0; bus.menu_sel = 2'd0;
      bus.amount_valid = 1'b0; bus.amount = 16'd0;

      // Reset state
      #12;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_bv", 32'(bus.balance_valid), 32'd0);
      check("rst_bo", 32'(bus.balance_out), 32'd0);
      check("rst_acc", 32'(bus.auth_acc), 32'd0);
      check("rst_deauth", 32'(bus.auth_deauth), 32'd0);
      rst_n = 1'b1;

      // Card 2749, PIN 0, balance query: full state walk
      card(12'd2749);
      check("t1_s1", 32'(bus.state), 32'd1);
      check("t1_acc", 32'(bus.auth_acc), 32'd2749);
      check("t1_act0", 32'(bus.auth_action), 32'd0);
      tick(); check("t1_s2", 32'(bus.state), 32'd2);
      tick(); check("t1_s3", 32'(bus.state), 32'd3);
      pin(4'd0);
      check("t1_s4", 32'(bus.state), 32'd4);
      check("t1_act1", 32'(bus.auth_action), 32'd1);
      tick(); check("t1_s5", 32'(bus.state), 32'd5);
      tick(); check("t1_s6", 32'(bus.state), 32'd6);
      menu(2'b01);
      check("t1_s7", 32'(bus.state), 32'd7);
      check("t1_bv", 32'(bus.balance_valid), 32'd1);
      check("t1_bo", 32'(bus.balance_out), 32'd500);
      check("t1_err", 32'(bus.err), 32'd0);
      tick();
      check("t1_back", 32'(bus.state), 32'd6);
      check("t1_bv0", 32'(bus.balance_valid), 32'd0);
      menu(2'b11);
      check("t1_deauth_st", 32'(bus.state), 32'd10);
      check("t1_deauth", 32'(bus.auth_deauth), 32'd1);
      check("t1_acc_clr", 32'(bus.auth_acc), 32'd0);
      tick();
      check("t1_wait", 32'(bus.state), 32'd0);
      check("t1_deauth0", 32'(bus.auth_deauth), 32'd0);

      // Card 2175, withdrawals
      to_menu("t2", 12'd2175, 4'd1);
      menu(2'b10); check("t2_wd", 32'(bus.state), 32'd8);
      amt(16'd120);
      check("t2_show", 32'(bus.state), 32'd9);
      check("t2_show_bo", 32'(bus.balance_out), 32'd380);
      check("t2_show_bv", 32'(bus.balance_valid), 32'd1);
      tick(); check("t2_menu", 32'(bus.state), 32'd6);
      menu(2'b01); check("t2_bal", 32'(bus.balance_out), 32'd380);
      tick();
      menu(2'b10); amt(16'd381);
      check("t2_nsf_st", 32'(bus.state), 32'd6);
      check("t2_nsf_err", 32'(bus.err), 32'd4);
      check("t2_nsf_bv", 32'(bus.balance_valid), 32'd0);
      menu(2'b01);
      check("t2_bal2", 32'(bus.balance_out), 32'd380);
      check("t2_err_clr", 32'(bus.err), 32'd0);
      tick();
      menu(2'b10); amt(16'd0);
      check("t2_zero_st", 32'(bus.state), 32'd9);
      check("t2_zero_bo", 32'(bus.balance_out), 32'd380);
      tick(); menu(2'b11); tick();
      check("t2_end", 32'(bus.state), 32'd0);

      // Unknown account
      card(12'd1234);
      tick(); check("t3_s2", 32'(bus.state), 32'd2);
      tick();
      check("t3_wait", 32'(bus.state), 32'd0);
      check("t3_err", 32'(bus.err), 32'd1);
      check("t3_nodeauth", 32'(bus.auth_deauth), 32'd0);

      // Lockout after three wrong PINs
      card(12'd2429); tick(); tick();
      pin(4'd5); tick(); tick();
      check("t4_try1_st", 32'(bus.state), 32'd3);
      check("t4_try1_err", 32'(bus.err), 32'd2);
      pin(4'd6); tick(); tick();
      check("t4_try2_err", 32'(bus.err), 32'd2);
      pin(4'd7); tick(); tick();
      check("t4_lock_st", 32'(bus.state), 32'd10);
      check("t4_lock_err", 32'(bus.err), 32'd3);
      check("t4_lock_deauth", 32'(bus.auth_deauth), 32'd1);
      tick();
      check("t4_wait", 32'(bus.state), 32'd0);
      check("t4_deauth_once", 32'(bus.auth_deauth), 32'd0);
      card(12'd2429); tick(); tick();
      check("t4_relock_st", 32'(bus.state), 32'd0);
      check("t4_relock_err", 32'(bus.err), 32'd3);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      to_menu("t4_unlock", 12'd2429, 4'd2);
      menu(2'b11); tick();

      // Inactivity timeout in MENU
      to_menu("t5", 12'd2910, 4'd7);
      card(12'd1234);
      check("t5_card_ign_st", 32'(bus.state), 32'd6);
      check("t5_card_ign_acc", 32'(bus.auth_acc), 32'd2910);
      menu(2'b00);
      check("t5_sel00", 32'(bus.state), 32'd6);
      repeat (999) tick();
      check("t5_still_menu", 32'(bus.state), 32'd6);
      tick();
      check("t5_to_st", 32'(bus.state), 32'd10);
      check("t5_to_err", 32'(bus.err), 32'd5);
      check("t5_to_deauth", 32'(bus.auth_deauth), 32'd1);
      tick();
      check("t5_wait", 32'(bus.state), 32'd0);
      check("t5_deauth_once", 32'(bus.auth_deauth), 32'd0);
      to_menu("t5b", 12'd2910, 4'd7);
      repeat (999) tick();
      menu(2'b01);
      check("t5_last_st", 32'(bus.state), 32'd7);
      check("t5_last_bo", 32'(bus.balance_out), 32'd500);
      check("t5_last_err", 32'(bus.err), 32'd0);
      tick(); menu(2'b11); tick();

      // Asynchronous reset during WITHDRAW
      to_menu("t6", 12'd2175, 4'd1);
      menu(2'b10); amt(16'd100);
      check("t6_bo", 32'(bus.balance_out), 32'd400);
      tick(); menu(2'b10);
      check("t6_wd", 32'(bus.state), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_st", 32'(bus.state), 32'd0);
      check("t6_rst_bo", 32'(bus.balance_out), 32'd0);
      check("t6_rst_bv", 32'(bus.balance_valid), 32'd0);
      check("t6_rst_acc", 32'(bus.auth_acc), 32'd0);
      check("t6_rst_pin", 32'(bus.auth_pin), 32'd0);
      check("t6_rst_act", 32'(bus.auth_action), 32'd0);
      check("t6_rst_deauth", 32'(bus.auth_deauth), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      check("t6_no_deauth", 32'(bus.auth_deauth), 32'd0);
      to_menu("t6b", 12'd2175, 4'd1);
      menu(2'b01);
      check("t6_bal_restored", 32'(bus.balance_out), 32'd500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Session sequencer for the ATM account-authentication datapath, a combinational lookup of 12-bit account number plus 4-bit PIN against a 10-entry table.
- Drives the lookup's request inputs: account, PIN, action (FIND=0 / AUTHENTICATE=1) and deAuth.
- Samples its result (success, 4-bit account index).
- Owns the per-account balance store, per-account PIN-lockout flags, the retry counter and the inactivity timeout.
- Sits between the front-panel input logic and the authentication/balance resources.

Parameters:
- NUM_ACC, 10: number of accounts; sizes the balance store and lock flags.
- MAX_TRIES, 3: consecutive wrong PINs before an account locks.
- TIMEOUT_CYCLES, 1000: idle cycles allowed in PIN_WAIT / MENU / WITHDRAW.
- INIT_BALANCE, 500: reset value of every 16-bit balance.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- card_valid, input, 1: one-cycle strobe; card_acc is valid.
- card_acc, input, 12: inserted account number.
- pin_valid, input, 1: one-cycle strobe; pin_in is valid.
- pin_in, input, 4: entered PIN.
- menu_valid, input, 1: one-cycle strobe; menu_sel is valid.
- menu_sel, input, 2: 01 = balance, 10 = withdraw, 11 = exit, 00 = ignored.
- amount_valid, input, 1: one-cycle strobe; amount is valid.
- amount, input, 16: withdrawal amount.
- auth_acc, output, 12: account number driven to the lookup.
- auth_pin, output, 4: PIN driven to the lookup.
- auth_action, output, 1: 0 = FIND, 1 = AUTHENTICATE.
- auth_deauth, output, 1: deAuth pulse to the lookup.
- auth_success, input, 1: lookup success flag.
- auth_index, input, 4: lookup account index.
- state, output, 4: current FSM state code.
- balance_out, output, 16: balance shown to the display.
- balance_valid, output, 1: one-cycle display strobe.
- err, output, 3: 0 none, 1 unknown account, 2 wrong PIN, 3 locked, 4 insufficient funds, 5 timeout.

Behaviour:
- Reset (async, rst_n=0), applied immediately:
  - state = WAITING.
  - auth_acc, auth_pin, auth_action, auth_deauth = 0.
  - balance_out = 0, balance_valid = 0, err = 0.
  - Every balance = INIT_BALANCE; all lock flags = 0; try counter = 0; timeout counter = 0.
  - Reset mid-session discards the session; no deAuth pulse is issued.
- All outputs are registered. The lookup is combinational; its result is sampled exactly one cycle after the request is registered.
- State codes:
  - WAITING = 0, FIND_REQ = 1, FIND_CHK = 2, PIN_WAIT = 3, AUTH_REQ = 4, AUTH_CHK = 5.
  - MENU = 6, BALANCE = 7, WITHDRAW = 8, WITHDRAW_SHOW_BALANCE = 9, DEAUTH = 10.
- WAITING:
  - card_valid: latch card_acc into auth_acc, auth_action = 0, err = 0, try counter = 0 -> FIND_REQ.
- FIND_REQ -> FIND_CHK unconditionally; this is the request settle cycle.
- FIND_CHK:
  - auth_success = 0: err = 1 -> WAITING.
  - Lock flag[auth_index] set: err = 3 -> WAITING.
  - Otherwise: latch auth_index into the internal session index -> PIN_WAIT.
- PIN_WAIT:
  - pin_valid: auth_pin = pin_in, auth_action = 1 -> AUTH_REQ.
- AUTH_REQ -> AUTH_CHK unconditionally.
- AUTH_CHK, auth_success = 1 and auth_index == session index:
  - Try counter = 0, err = 0 -> MENU.
- AUTH_CHK, otherwise (wrong PIN):
  - Try counter +1 and err = 2.
  - If the new count == MAX_TRIES: set lock flag[index], err = 3 -> DEAUTH.
  - Else -> PIN_WAIT.
- MENU, on menu_valid (err cleared on any accepted menu_valid):
  - 01 -> BALANCE.
  - 10 -> WITHDRAW.
  - 11 -> DEAUTH.
  - 00 -> stay in MENU.
- BALANCE:
  - One cycle with balance_out = balance[index], balance_valid = 1 -> MENU.
- WITHDRAW, on amount_valid:
  - amount > balance[index]: err = 4, balance unchanged -> MENU.
  - Otherwise: balance[index] -= amount -> WITHDRAW_SHOW_BALANCE.
  - amount = 0 is a legal no-op withdrawal.
- WITHDRAW_SHOW_BALANCE:
  - One cycle with balance_out = new balance, balance_valid = 1 -> MENU.
- DEAUTH:
  - auth_deauth = 1 for exactly one cycle.
  - auth_acc, auth_pin and auth_action are cleared to 0.
  - -> WAITING.
- Timeout:
  - The counter clears on every state change and on every accepted strobe.
  - It increments only in PIN_WAIT, MENU and WITHDRAW.
  - When it reaches TIMEOUT_CYCLES-1: err = 5 -> DEAUTH.
  - If a strobe is accepted in the same cycle the counter reaches TIMEOUT_CYCLES-1, the strobe wins.
- Strobe handling:
  - Strobes not relevant to the current state are ignored with no side effect; this includes card_valid during a session.
  - Simultaneous strobes: only the one relevant to the current state is acted on.
- Lock flags clear only on reset.
- balance_valid is 0 in every state other than BALANCE and WITHDRAW_SHOW_BALANCE.

Test Plan:
- Card 2749, PIN 0, menu 01:
  - State sequence 0,1,2,3,4,5,6,7,6.
  - balance_out = 500, balance_valid high for 1 cycle, err = 0.
- Card 2175, PIN 1, withdraw 120, then menu 01:
  - WITHDRAW_SHOW_BALANCE shows 380; a later BALANCE shows 380.
  - Withdraw 381 -> err = 4, balance stays 380, state = MENU.
- Card 1234 -> err = 1, back to WAITING 2 cycles after card_valid, no deAuth pulse.
- Card 2429, PINs 5, 6, 7:
  - err = 2 after the first two attempts.
  - err = 3 and one auth_deauth pulse after the third.
  - Re-insert 2429 -> err = 3 at FIND_CHK, WAITING.
  - Reset -> 2429 with PIN 2 reaches MENU.
- Card 2910, PIN 7, then idle for TIMEOUT_CYCLES cycles in MENU:
  - err = 5, one-cycle auth_deauth, WAITING.
  - A menu_valid landing on the final idle cycle is honoured instead.
- Assert rst_n low during WITHDRAW after a completed 100 withdrawal:
  - All outputs return to their reset values immediately (asynchronously).
  - The balance returns to 500; no auth_deauth pulse occurs.
